// File: rtl/audio_player.sv
// audio_player: streams a fixed-length signed 16-bit clip out of a synchronous
// audio ROM at the sample rate and renders the current sample as 1-bit PWM.
//
// Parameters
//   CLK_HZ       system clock frequency in Hz
//   SAMPLE_HZ    playback sample rate in Hz (DIV = CLK_HZ / SAMPLE_HZ)
//   DEPTH        number of samples in the clip
//   LOOP         1 = wrap to sample 0 at clip end, 0 = stop at clip end
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         pulse: play from 0 (IDLE/DONE/PLAY) or resume (PAUSE)
//   pause         pulse: freeze playback (PLAY only)
//   stop          pulse: abort and return to IDLE, flushing any fetch
//   rom_addr      registered ROM sample address
//   rom_data      ROM sample, valid one clock after rom_addr changes
//   sample_out    latest fetched sample (registered)
//   sample_valid  one-cycle strobe when sample_out is updated
//   pwm_out       registered PWM rendering of sample_out
//   busy          high in PLAY and PAUSE (decoded from the state register)
//   done          one-cycle strobe with the final sample of a non-looping clip
module audio_player #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned SAMPLE_HZ = 44100,
    parameter int unsigned DEPTH     = 176400,
    parameter int unsigned LOOP      = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    output logic [17:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic        pwm_out,
    output logic        busy,
    output logic        done
);

    localparam int unsigned ADDR_W   = 18;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned PWM_W    = 10;
    localparam int unsigned DIV      = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam bit                STOP_AT_END = (LOOP == 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Registered state
    state_t                state, state_d;
    logic [DIV_W-1:0]      div_cnt, div_d;
    logic [ADDR_W-1:0]     addr_cnt, addr_d;
    logic [ADDR_W-1:0]     rom_addr_d;
    logic                  p1_valid, p1_valid_d;   // address issued to ROM
    logic                  p1_last, p1_last_d;
    logic                  p2_valid, p2_valid_d;   // ROM data now on rom_data
    logic                  p2_last, p2_last_d;
    logic [SAMPLE_W-1:0]   sample_out_d;
    logic                  sample_valid_d;
    logic                  done_d;
    logic [PWM_W-1:0]      pwm_cnt, pwm_cnt_d;
    logic                  pwm_out_d;

    // Combinational decode
    logic                  tick_c;
    logic                  last_pending_c;
    logic                  issue_c;
    logic                  flush_c;
    logic                  finish_c;
    logic [PWM_W-1:0]      level_c;

    // Sample-rate tick: divider wraps while playing
    assign tick_c = (state == S_PLAY) && (div_cnt == DIV_LAST);

    // Once the final sample is in flight on a non-looping clip, stop issuing
    assign last_pending_c = STOP_AT_END &&
                            ((p1_valid && p1_last) || (p2_valid && p2_last));

    // A command in the tick cycle takes precedence over issuing a fetch
    assign issue_c = tick_c && !stop && !start && !pause && !last_pending_c;

    // stop, or a restart from PLAY, discards every fetch in flight
    assign flush_c = stop || (start && (state == S_PLAY));

    // Final sample of a non-looping clip lands this cycle
    assign finish_c = STOP_AT_END && p2_valid && p2_last && !stop && !start;

    // Offset-binary: flip the sign bit, keep the top PWM_W bits
    assign level_c = {~sample_out[SAMPLE_W-1], sample_out[SAMPLE_W-2:SAMPLE_W-PWM_W]};

    assign busy = (state == S_PLAY) || (state == S_PAUSE);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            div_cnt      <= '0;
            addr_cnt     <= '0;
            rom_addr     <= '0;
            p1_valid     <= 1'b0;
            p1_last      <= 1'b0;
            p2_valid     <= 1'b0;
            p2_last      <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
            pwm_cnt      <= '0;
            pwm_out      <= 1'b0;
        end else begin
            state        <= state_d;
            div_cnt      <= div_d;
            addr_cnt     <= addr_d;
            rom_addr     <= rom_addr_d;
            p1_valid     <= p1_valid_d;
            p1_last      <= p1_last_d;
            p2_valid     <= p2_valid_d;
            p2_last      <= p2_last_d;
            sample_out   <= sample_out_d;
            sample_valid <= sample_valid_d;
            done         <= done_d;
            pwm_cnt      <= pwm_cnt_d;
            pwm_out      <= pwm_out_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state;
        div_d          = '0;
        addr_d         = addr_cnt;
        rom_addr_d     = rom_addr;
        p1_valid_d     = 1'b0;
        p1_last_d      = 1'b0;
        p2_valid_d     = 1'b0;
        p2_last_d      = 1'b0;
        sample_out_d   = sample_out;
        sample_valid_d = 1'b0;
        done_d         = 1'b0;
        pwm_cnt_d      = pwm_cnt + PWM_W'(1);
        pwm_out_d      = (pwm_cnt < level_c);

        // Command priority: stop > start > clip end > pause
        if (stop) begin
            state_d = S_IDLE;
        end else if (start) begin
            state_d = S_PLAY;
        end else if (finish_c) begin
            state_d = S_DONE;
        end else begin
            case (state)
                S_PLAY:  if (pause) state_d = S_PAUSE;
                default: state_d = state;
            endcase
        end

        // Divider runs only across PLAY->PLAY without a restart
        if ((state == S_PLAY) && (state_d == S_PLAY) && !start) begin
            div_d = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end

        // Stage 1: present address, advance (wrapping at the clip end)
        if (issue_c) begin
            rom_addr_d = addr_cnt;
            addr_d     = (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + ADDR_W'(1);
            p1_valid_d = 1'b1;
            p1_last_d  = (addr_cnt == ADDR_LAST);
        end

        // Stages 2 and 3: wait for ROM, then capture the sample
        if (!flush_c) begin
            p2_valid_d = p1_valid;
            p2_last_d  = p1_last;
            if (p2_valid) begin
                sample_valid_d = 1'b1;
                sample_out_d   = rom_data;
            end
        end

        done_d = finish_c;

        // Fresh play (not a resume) restarts the clip at sample 0
        if (start && (state != S_PAUSE)) begin
            addr_d = '0;
        end

        if (stop) begin
            addr_d       = '0;
            rom_addr_d   = '0;
            sample_out_d = '0;
        end
    end

endmodule

// File: tb/tb_audio_player.sv
// Testbench for audio_player: DIV=4, DEPTH=8, one non-looping and one looping
// instance, each with a 1-cycle ROM model; expected samples are queued by the
// stimulus and checked by a per-instance monitor.
module tb_audio_player;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Non-looping instance
    logic        m_start, m_pause, m_stop;
    logic [17:0] m_rom_addr;
    logic [15:0] m_rom_data;
    logic [15:0] m_sample;
    logic        m_valid, m_pwm, m_busy, m_done;

    // Looping instance
    logic        l_start, l_pause, l_stop;
    logic [17:0] l_rom_addr;
    logic [15:0] l_rom_data;
    logic [15:0] l_sample;
    logic        l_valid, l_pwm, l_busy, l_done;

    // ROM content select for the PWM test
    logic        rom_mode;
    logic [15:0] pwm_val;

    audio_player #(.CLK_HZ(4), .SAMPLE_HZ(1), .DEPTH(8), .LOOP(0)) u_main (
        .clk(clk), .rst_n(rst_n),
        .start(m_start), .pause(m_pause), .stop(m_stop),
        .rom_addr(m_rom_addr), .rom_data(m_rom_data),
        .sample_out(m_sample), .sample_valid(m_valid),
        .pwm_out(m_pwm), .busy(m_busy), .done(m_done)
    );

    audio_player #(.CLK_HZ(4), .SAMPLE_HZ(1), .DEPTH(8), .LOOP(1)) u_loop (
        .clk(clk), .rst_n(rst_n),
        .start(l_start), .pause(l_pause), .stop(l_stop),
        .rom_addr(l_rom_addr), .rom_data(l_rom_data),
        .sample_out(l_sample), .sample_valid(l_valid),
        .pwm_out(l_pwm), .busy(l_busy), .done(l_done)
    );

    // ROM models: data one clock after the address
    always @(posedge clk) begin
        m_rom_data <= rom_mode ? pwm_val : 16'h1000 + m_rom_addr[15:0];
        l_rom_data <= 16'h1000 + l_rom_addr[15:0];
    end

    typedef struct packed {
        logic [15:0] val;
        logic        done;
    } exp_t;

    exp_t m_q[$];
    exp_t l_q[$];
    exp_t m_e, l_e;

    int tests = 0;
    int fails = 0;

    logic [17:0] m_max_addr = '0;
    logic [17:0] l_max_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_main(input logic [15:0] v, input logic d);
        exp_t e;
        e.val  = v;
        e.done = d;
        m_q.push_back(e);
    endtask

    task automatic push_loop(input logic [15:0] v, input logic d);
        exp_t e;
        e.val  = v;
        e.done = d;
        l_q.push_back(e);
    endtask

    // One-cycle command pulse on the non-looping instance
    task automatic pulse_main(input logic s_start, input logic s_pause, input logic s_stop);
        m_start = s_start;
        m_pause = s_pause;
        m_stop  = s_stop;
        @(negedge clk);
        m_start = 1'b0;
        m_pause = 1'b0;
        m_stop  = 1'b0;
    endtask

    // Cycles until a strobe carrying v, or -1 on timeout
    task automatic wait_main(input logic [15:0] v, input int limit, output int k);
        k = 0;
        while (!(m_valid && (m_sample == v)) && (k < limit)) begin
            @(negedge clk);
            k++;
        end
        if (!(m_valid && (m_sample == v))) k = -1;
    endtask

    // Cycles until done, or -1 on timeout
    task automatic wait_done_main(input int limit, output int k);
        k = 0;
        while (!m_done && (k < limit)) begin
            @(negedge clk);
            k++;
        end
        if (!m_done) k = -1;
    endtask

    // Count high cycles of pwm_out over one full PWM period
    task automatic measure_pwm(output int cnt);
        cnt = 0;
        repeat (1024) begin
            @(negedge clk);
            if (m_pwm) cnt++;
        end
    endtask

    // Scoreboard monitor, non-looping instance
    always @(negedge clk) begin
        if (m_rom_addr > m_max_addr) m_max_addr = m_rom_addr;
        if (m_valid) begin
            tests++;
            if (m_q.size() == 0) begin
                fails++;
                $display("FAIL main strobe: got sample %0h done %0b, no strobe expected", m_sample, m_done);
            end else begin
                m_e = m_q.pop_front();
                if ((m_sample !== m_e.val) || (m_done !== m_e.done)) begin
                    fails++;
                    $display("FAIL main strobe: got sample %0h done %0b, expected %0h done %0b",
                             m_sample, m_done, m_e.val, m_e.done);
                end
            end
        end else if (m_done) begin
            tests++;
            fails++;
            $display("FAIL main done: got done=1 without strobe, expected 0");
        end
    end

    // Scoreboard monitor, looping instance
    always @(negedge clk) begin
        if (l_rom_addr > l_max_addr) l_max_addr = l_rom_addr;
        if (l_valid) begin
            tests++;
            if (l_q.size() == 0) begin
                fails++;
                $display("FAIL loop strobe: got sample %0h done %0b, no strobe expected", l_sample, l_done);
            end else begin
                l_e = l_q.pop_front();
                if ((l_sample !== l_e.val) || (l_done !== l_e.done)) begin
                    fails++;
                    $display("FAIL loop strobe: got sample %0h done %0b, expected %0h done %0b",
                             l_sample, l_done, l_e.val, l_e.done);
                end
            end
        end else if (l_done) begin
            tests++;
            fails++;
            $display("FAIL loop done: got done=1 without strobe, expected 0");
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        int cnt;

        rst_n    = 1'b0;
        m_start  = 1'b0; m_pause = 1'b0; m_stop = 1'b0;
        l_start  = 1'b0; l_pause = 1'b0; l_stop = 1'b0;
        rom_mode = 1'b0;
        pwm_val  = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset rom_addr", 32'(m_rom_addr), 32'h0);
        check("reset sample_out", 32'(m_sample), 32'h0);
        check("reset valid/done/busy/pwm", 32'({m_valid, m_done, m_busy, m_pwm}), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Looping clip: 20 samples wrap through the clip with no done
        for (int i = 0; i < 20; i++) push_loop(16'h1000 + 16'(i % 8), 1'b0);
        l_start = 1'b1;
        @(negedge clk);
        l_start = 1'b0;
        n = 0;
        k = 0;
        while ((n < 20) && (k < 200)) begin
            @(negedge clk);
            k++;
            if (l_valid) n++;
        end
        l_stop = 1'b1;
        @(negedge clk);
        l_stop = 1'b0;
        check("loop strobe count", 32'(n), 32'd20);
        repeat (10) @(negedge clk);
        check("loop busy after stop", 32'(l_busy), 32'h0);

        // Basic play: first strobe 3 cycles after the 4th PLAY cycle
        for (int i = 0; i < 8; i++) push_main(16'h1000 + 16'(i), (i == 7));
        pulse_main(1'b1, 1'b0, 1'b0);
        check("busy in play", 32'(m_busy), 32'h1);
        wait_main(16'h1000, 20, k);
        check("start to first strobe cycles", 32'(k + 1), 32'd7);
        wait_done_main(60, k);
        check("first strobe to done cycles", 32'(k), 32'd28);
        check("busy at done", 32'(m_busy), 32'h0);
        @(negedge clk);
        check("done one cycle", 32'(m_done), 32'h0);
        check("sample held in done", 32'(m_sample), 32'h1007);

        // Pause after 1002, hold 50 cycles, resume at 1003
        push_main(16'h1000, 1'b0);
        push_main(16'h1001, 1'b0);
        push_main(16'h1002, 1'b0);
        pulse_main(1'b1, 1'b0, 1'b0);
        wait_main(16'h1002, 40, k);
        check("reached 1002", 32'(k >= 0), 32'h1);
        pulse_main(1'b0, 1'b1, 1'b0);
        repeat (50) @(negedge clk);
        check("paused sample held", 32'(m_sample), 32'h1002);
        check("busy in pause", 32'(m_busy), 32'h1);
        for (int i = 3; i < 8; i++) push_main(16'h1000 + 16'(i), (i == 7));
        pulse_main(1'b1, 1'b0, 1'b0);
        wait_done_main(60, k);
        check("resume to done cycles", 32'(k), 32'd22);
        @(negedge clk);

        // Stop in the cycle after a tick flushes the in-flight fetch
        push_main(16'h1000, 1'b0);
        pulse_main(1'b1, 1'b0, 1'b0);
        wait_main(16'h1000, 20, k);
        @(negedge clk);
        @(negedge clk);
        check("rom_addr in flight", 32'(m_rom_addr), 32'h1);
        pulse_main(1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("stop sample_out", 32'(m_sample), 32'h0);
        check("stop rom_addr", 32'(m_rom_addr), 32'h0);
        check("stop busy", 32'(m_busy), 32'h0);

        // stop and start together: stop wins
        push_main(16'h1000, 1'b0);
        pulse_main(1'b1, 1'b0, 1'b0);
        wait_main(16'h1000, 20, k);
        @(negedge clk);
        pulse_main(1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("stop+start busy", 32'(m_busy), 32'h0);
        check("stop+start sample_out", 32'(m_sample), 32'h0);

        // Asynchronous reset between edges mid-play
        push_main(16'h1000, 1'b0);
        push_main(16'h1001, 1'b0);
        pulse_main(1'b1, 1'b0, 1'b0);
        wait_main(16'h1001, 30, k);
        @(negedge clk);
        @(negedge clk);
        check("rom_addr before reset", 32'(m_rom_addr), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("async rom_addr", 32'(m_rom_addr), 32'h0);
        check("async sample_out", 32'(m_sample), 32'h0);
        check("async valid/done/busy", 32'({m_valid, m_done, m_busy}), 32'h0);
        check("async pwm_out", 32'(m_pwm), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle after reset", 32'(m_busy), 32'h0);

        // PWM duty for full-scale positive, full-scale negative, and zero
        rom_mode = 1'b1;
        pwm_val  = 16'h7FFF;
        for (int i = 0; i < 8; i++) push_main(16'h7FFF, (i == 7));
        pulse_main(1'b1, 1'b0, 1'b0);
        wait_done_main(60, k);
        measure_pwm(cnt);
        check("pwm duty 7fff", 32'(cnt), 32'd1023);

        pwm_val = 16'h8000;
        for (int i = 0; i < 8; i++) push_main(16'h8000, (i == 7));
        pulse_main(1'b1, 1'b0, 1'b0);
        wait_done_main(60, k);
        measure_pwm(cnt);
        check("pwm duty 8000", 32'(cnt), 32'd0);

        pulse_main(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        measure_pwm(cnt);
        check("pwm duty zero", 32'(cnt), 32'd512);

        // Drain checks
        check("main queue empty", 32'(m_q.size()), 32'd0);
        check("loop queue empty", 32'(l_q.size()), 32'd0);
        check("main rom_addr in range", 32'(m_max_addr < 18'd8), 32'h1);
        check("loop rom_addr in range", 32'(l_max_addr < 18'd8), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
